// File: rtl/block_state_arbiter_if.sv
// block_state_arbiter_if
// Bundles the level-control, renderer and controller signals of the block
// state arbiter.
//   LEVEL_RESTART             refill pulse from the game FSM
//   RND_REQ/RND_ADDR          renderer read request
//   RND_ALIVE                 renderer read data (one cycle later)
//   CTL_REQ/CTL_OP/CTL_ADDR   controller request, held until CTL_ACK
//   CTL_ACK/CTL_ALIVE         controller completion pulse and old block value
//   ALIVE_COUNT/BUSY/ALL_CLEARED  level status
// master = game side (drives requests), slave = arbiter.
interface block_state_arbiter_if #(
    parameter int ADDR_WIDTH = 7
);
    logic                  LEVEL_RESTART;
    logic                  RND_REQ;
    logic [ADDR_WIDTH-1:0] RND_ADDR;
    logic                  RND_ALIVE;
    logic                  CTL_REQ;
    logic                  CTL_OP;
    logic [ADDR_WIDTH-1:0] CTL_ADDR;
    logic                  CTL_ACK;
    logic                  CTL_ALIVE;
    logic [ADDR_WIDTH:0]   ALIVE_COUNT;
    logic                  BUSY;
    logic                  ALL_CLEARED;

    modport master (
        output LEVEL_RESTART, RND_REQ, RND_ADDR, CTL_REQ, CTL_OP, CTL_ADDR,
        input  RND_ALIVE, CTL_ACK, CTL_ALIVE, ALIVE_COUNT, BUSY, ALL_CLEARED
    );

    modport slave (
        input  LEVEL_RESTART, RND_REQ, RND_ADDR, CTL_REQ, CTL_OP, CTL_ADDR,
        output RND_ALIVE, CTL_ACK, CTL_ALIVE, ALIVE_COUNT, BUSY, ALL_CLEARED
    );
endinterface

// File: rtl/block_state_arbiter.sv
// block_state_arbiter
// Holds the alive bit of every breakout block behind a single access port.
// The renderer has strict priority and gets a registered read every cycle it
// asks; the controller's handshaked read/kill ops use the idle slots. A
// level fill writes every block alive, one per cycle, and ALIVE_COUNT tracks
// the blocks left for end-of-level detection.
// Ports:
//   CLK    system clock (40 MHz)
//   RESET  synchronous, active-high reset
//   bus    block_state_arbiter_if.slave (see interface header)
module block_state_arbiter #(
    parameter int NUM_BLOCKS = 112,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  CLK,
    input  logic                  RESET,
    block_state_arbiter_if.slave  bus
);
    localparam logic [ADDR_WIDTH:0]   NB        = (ADDR_WIDTH+1)'(NUM_BLOCKS);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_BLOCKS - 1);

    typedef enum logic {FILL, SERVE} state_t;

    state_t                state_q, state_d;
    logic [NUM_BLOCKS-1:0] blocks;
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic [ADDR_WIDTH:0]   alive_count;
    logic                  rnd_alive_q;
    logic                  ctl_ack_q;
    logic                  ctl_alive_q;
    logic                  ctl_grant;
    logic                  rnd_bit;
    logic                  ctl_bit;

    // Out-of-range addresses read as dead; the range check also keeps the
    // kill write below from ever targeting a nonexistent block.
    assign rnd_bit = ({1'b0, bus.RND_ADDR} < NB) && blocks[bus.RND_ADDR];
    assign ctl_bit = ({1'b0, bus.CTL_ADDR} < NB) && blocks[bus.CTL_ADDR];

    always_ff @(posedge CLK) begin
        state_q <= state_d;
    end

    // A restart wins over everything. The controller is granted only in
    // SERVE, only when the renderer is idle, and never while its previous ack
    // is still showing, so a held request is not served twice.
    always_comb begin
        state_d   = state_q;
        ctl_grant = 1'b0;
        if (RESET || bus.LEVEL_RESTART) begin
            state_d = FILL;
        end else begin
            case (state_q)
                FILL:    if (fill_addr == LAST_ADDR) state_d = SERVE;
                SERVE:   ctl_grant = !bus.RND_REQ && bus.CTL_REQ && !ctl_ack_q;
                default: state_d = FILL;
            endcase
        end
    end

    // The block array is not reset: every bit is rewritten by the fill before
    // any read or grant can observe it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fill_addr   <= '0;
            alive_count <= '0;
            rnd_alive_q <= 1'b0;
            ctl_ack_q   <= 1'b0;
            ctl_alive_q <= 1'b0;
        end else if (bus.LEVEL_RESTART) begin
            fill_addr   <= '0;
            alive_count <= '0;
            ctl_ack_q   <= 1'b0;
            if (bus.RND_REQ) rnd_alive_q <= 1'b0;
        end else begin
            ctl_ack_q <= ctl_grant;
            if (bus.RND_REQ) rnd_alive_q <= (state_q == SERVE) && rnd_bit;
            if (state_q == FILL) begin
                blocks[fill_addr] <= 1'b1;
                fill_addr         <= fill_addr + 1'b1;
                alive_count       <= alive_count + 1'b1;
            end
            if (ctl_grant) begin
                ctl_alive_q <= ctl_bit;
                // Only a live block changes the count, so a double kill or
                // an out-of-range kill leaves it alone.
                if (bus.CTL_OP && ctl_bit) begin
                    blocks[bus.CTL_ADDR] <= 1'b0;
                    if (alive_count != '0) alive_count <= alive_count - 1'b1;
                end
            end
        end
    end

    assign bus.RND_ALIVE   = rnd_alive_q;
    assign bus.CTL_ACK     = ctl_ack_q;
    assign bus.CTL_ALIVE   = ctl_alive_q;
    assign bus.ALIVE_COUNT = alive_count;
    assign bus.BUSY        = (state_q == FILL);
    assign bus.ALL_CLEARED = (alive_count == '0) && (state_q == SERVE);
endmodule

// File: tb/tb_block_state_arbiter.sv
module tb_block_state_arbiter;
    localparam int NB = 112;
    localparam int AW = 7;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    block_state_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    block_state_arbiter #(.NUM_BLOCKS(NB), .ADDR_WIDTH(AW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Table vectors: one cycle of inputs and the outputs expected after it.
    typedef struct {
        logic       rr;
        logic [6:0] ra;
        logic       cr;
        logic       op;
        logic [6:0] ca;
        logic       er;
        logic       ea;
        logic       ec;
        int         cnt;
    } vec_t;
    vec_t tbl[17];

    // Reference model: set of alive blocks plus fill progress.
    bit alive_m[128];
    int phase_m;
    bit busy_m;
    bit rnd_e, ack_e, cal_e;

    function automatic bit rd_m(input int a);
        return (a < NB) ? alive_m[a] : 1'b0;
    endfunction

    function automatic int alive_total();
        int s = 0;
        for (int i = 0; i < 128; i++) s += int'(alive_m[i]);
        return s;
    endfunction

    function automatic int count_m();
        return busy_m ? phase_m : alive_total();
    endfunction

    task automatic model_step(input bit lr, input bit rr, input int ra,
                              input bit cr, input bit op, input int ca);
        bit grant;
        if (lr) begin
            busy_m = 1; phase_m = 0; ack_e = 0;
            if (rr) rnd_e = 0;
        end else if (busy_m) begin
            if (rr) rnd_e = 0;
            ack_e = 0;
            phase_m++;
            if (phase_m == NB) begin
                busy_m = 0;
                for (int i = 0; i < 128; i++) alive_m[i] = (i < NB);
            end
        end else begin
            grant = !rr && cr && !ack_e;
            if (rr) rnd_e = rd_m(ra);
            if (grant) begin
                cal_e = rd_m(ca);
                if (op && ca < NB) alive_m[ca] = 0;
            end
            ack_e = grant;
        end
    endtask

    task automatic wait_idle(input string nm, output int cycles);
        cycles = 0;
        while (bus.BUSY && cycles < 400) begin
            tick();
            cycles++;
        end
        if (bus.BUSY) chk({nm, "_timeout"}, 1, 0);
    endtask

    initial begin
        int n, miss, ack_k, acks, cal_k, stuck;
        bit cr_r, op_r, lr_r, rr_r;
        int ra_r, ca_r;

        bus.LEVEL_RESTART = 0; bus.RND_REQ = 0; bus.RND_ADDR = '0;
        bus.CTL_REQ = 0; bus.CTL_OP = 0; bus.CTL_ADDR = '0;

        tbl[0]  = '{1, 7'd0,   0, 0, 7'd0,   1, 0, 0, 112};
        tbl[1]  = '{1, 7'd111, 0, 0, 7'd0,   1, 0, 0, 112};
        tbl[2]  = '{1, 7'd112, 0, 0, 7'd0,   0, 0, 0, 112};
        tbl[3]  = '{0, 7'd0,   1, 1, 7'd5,   0, 1, 1, 111};
        tbl[4]  = '{0, 7'd0,   0, 0, 7'd0,   0, 0, 1, 111};
        tbl[5]  = '{0, 7'd0,   1, 1, 7'd5,   0, 1, 0, 111};
        tbl[6]  = '{0, 7'd0,   0, 0, 7'd0,   0, 0, 0, 111};
        tbl[7]  = '{1, 7'd5,   0, 0, 7'd0,   0, 0, 0, 111};
        tbl[8]  = '{1, 7'd6,   0, 0, 7'd0,   1, 0, 0, 111};
        tbl[9]  = '{0, 7'd0,   1, 0, 7'd6,   1, 1, 1, 111};
        tbl[10] = '{0, 7'd0,   0, 0, 7'd0,   1, 0, 1, 111};
        tbl[11] = '{0, 7'd0,   1, 1, 7'd127, 1, 1, 0, 111};
        tbl[12] = '{0, 7'd0,   0, 0, 7'd0,   1, 0, 0, 111};
        tbl[13] = '{1, 7'd5,   1, 1, 7'd7,   0, 0, 0, 111};
        tbl[14] = '{0, 7'd0,   1, 1, 7'd7,   0, 1, 1, 110};
        tbl[15] = '{0, 7'd0,   1, 1, 7'd7,   0, 0, 1, 110};
        tbl[16] = '{0, 7'd0,   0, 0, 7'd0,   0, 0, 1, 110};

        // Reset values
        repeat (3) tick();
        chk("rst_rnd_alive", bus.RND_ALIVE, 0);
        chk("rst_ctl_ack", bus.CTL_ACK, 0);
        chk("rst_ctl_alive", bus.CTL_ALIVE, 0);
        chk("rst_count", bus.ALIVE_COUNT, 0);
        chk("rst_busy", bus.BUSY, 1);
        chk("rst_all_cleared", bus.ALL_CLEARED, 0);

        // Initial fill: BUSY for NB cycles after reset release
        RESET = 0;
        wait_idle("fill", n);
        chk("fill_busy_cycles", n, NB);
        chk("fill_count", bus.ALIVE_COUNT, NB);

        // Table-driven vectors
        for (int i = 0; i < 17; i++) begin
            bus.RND_REQ = tbl[i].rr; bus.RND_ADDR = tbl[i].ra;
            bus.CTL_REQ = tbl[i].cr; bus.CTL_OP = tbl[i].op; bus.CTL_ADDR = tbl[i].ca;
            tick();
            chk($sformatf("vec%0d_rnd_alive", i), bus.RND_ALIVE, tbl[i].er);
            chk($sformatf("vec%0d_ctl_ack", i), bus.CTL_ACK, tbl[i].ea);
            chk($sformatf("vec%0d_ctl_alive", i), bus.CTL_ALIVE, tbl[i].ec);
            chk($sformatf("vec%0d_count", i), bus.ALIVE_COUNT, tbl[i].cnt);
        end
        bus.RND_REQ = 0; bus.CTL_REQ = 0;

        // Renderer starvation: no ack while RND_REQ is held
        bus.RND_REQ = 1; bus.RND_ADDR = 7'd0;
        bus.CTL_REQ = 1; bus.CTL_OP = 0; bus.CTL_ADDR = 7'd10;
        miss = 0;
        repeat (20) begin
            tick();
            if (bus.CTL_ACK) miss++;
        end
        chk("starve_no_ack", miss, 0);
        bus.RND_REQ = 0;
        tick();
        chk("starve_ack", bus.CTL_ACK, 1);
        chk("starve_ctl_alive", bus.CTL_ALIVE, 1);
        bus.CTL_REQ = 0;
        tick();

        // Kill every block; ALL_CLEARED rises with the final ack
        miss = 0;
        for (int i = 0; i < NB; i++) begin
            if (i == NB - 1) chk("killall_not_cleared_early", bus.ALL_CLEARED, 0);
            bus.CTL_REQ = 1; bus.CTL_OP = 1; bus.CTL_ADDR = 7'(i);
            tick();
            if (!bus.CTL_ACK) miss++;
            bus.CTL_REQ = 0;
            if (i == NB - 1) begin
                chk("killall_cleared", bus.ALL_CLEARED, 1);
                chk("killall_count", bus.ALIVE_COUNT, 0);
            end
            tick();
        end
        chk("killall_acks", miss, 0);

        bus.LEVEL_RESTART = 1;
        tick();
        bus.LEVEL_RESTART = 0;
        chk("restart_cleared_drop", bus.ALL_CLEARED, 0);
        chk("restart_busy", bus.BUSY, 1);
        chk("restart_count0", bus.ALIVE_COUNT, 0);
        wait_idle("refill", n);
        chk("refill_busy_cycles", n, NB);
        chk("refill_count", bus.ALIVE_COUNT, NB);

        // Restart in the middle of a fill
        bus.LEVEL_RESTART = 1;
        tick();
        bus.LEVEL_RESTART = 0;
        repeat (50) tick();
        chk("midfill_count50", bus.ALIVE_COUNT, 50);
        bus.LEVEL_RESTART = 1;
        tick();
        bus.LEVEL_RESTART = 0;
        chk("midfill_count_reset", bus.ALIVE_COUNT, 0);
        wait_idle("midfill", n);
        chk("midfill_busy_cycles", n, NB);

        // Controller request held through a fill
        bus.LEVEL_RESTART = 1;
        tick();
        bus.LEVEL_RESTART = 0;
        bus.CTL_REQ = 1; bus.CTL_OP = 0; bus.CTL_ADDR = 7'd3;
        acks = 0; ack_k = -1; cal_k = 0;
        for (int k = 1; k <= 120; k++) begin
            tick();
            if (bus.CTL_ACK) begin
                acks++;
                ack_k = k;
                cal_k = bus.CTL_ALIVE;
                bus.CTL_REQ = 0;
            end
        end
        chk("fillreq_acks", acks, 1);
        chk("fillreq_ack_cycle", ack_k, NB + 1);
        chk("fillreq_ctl_alive", cal_k, 1);

        // Randomised run against the reference model
        cal_e = 1;
        cr_r = 0; op_r = 0; ca_r = 0;
        stuck = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            lr_r = (cyc == 0) || ($urandom_range(0, 599) == 0);
            rr_r = (cyc == 0) || ($urandom_range(0, 1) == 1);
            ra_r = $urandom_range(0, 127);
            if (!cr_r && $urandom_range(0, 2) == 0) begin
                cr_r = 1;
                op_r = ($urandom_range(0, 3) != 0);
                ca_r = ($urandom_range(0, 9) == 0) ? $urandom_range(NB, 127) : $urandom_range(0, NB - 1);
            end
            bus.LEVEL_RESTART = lr_r; bus.RND_REQ = rr_r; bus.RND_ADDR = 7'(ra_r);
            bus.CTL_REQ = cr_r; bus.CTL_OP = op_r; bus.CTL_ADDR = 7'(ca_r);
            model_step(lr_r, rr_r, ra_r, cr_r, op_r, ca_r);
            tick();
            chk("rnd_rnd_alive", bus.RND_ALIVE, rnd_e);
            chk("rnd_ctl_ack", bus.CTL_ACK, ack_e);
            chk("rnd_ctl_alive", bus.CTL_ALIVE, cal_e);
            chk("rnd_count", bus.ALIVE_COUNT, count_m());
            chk("rnd_busy", bus.BUSY, busy_m);
            chk("rnd_all_cleared", bus.ALL_CLEARED, !busy_m && count_m() == 0);
            if (bus.CTL_ACK) begin
                cr_r = 0;
                stuck = 0;
            end else if (cr_r) begin
                stuck++;
            end
            // A request left hanging for this long means acks stopped arriving.
            if (stuck > 1000) begin
                chk("rnd_req_timeout", stuck, 0);
                cr_r = 0;
                stuck = 0;
            end
        end
        bus.LEVEL_RESTART = 0; bus.RND_REQ = 0; bus.CTL_REQ = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
